// File: rtl/warning_chime_ctrl.sv
// Cadenced chime and lamp driver downstream of warning_system.
// Optional WARN_LOG_EN adds a saturating count of warn_pri1 rising edges.
module warning_chime_ctrl #(
  parameter int unsigned TICK_DIV  = 4,
  parameter int unsigned P1_ON     = 2,
  parameter int unsigned P1_OFF    = 2,
  parameter int unsigned P2_ON     = 1,
  parameter int unsigned P2_OFF    = 3,
  parameter int unsigned P2_REPEAT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       warn_pri1,
  input  logic       warn_pri2,
  input  logic       ack,
  output logic       chime_out,
  output logic       lamp_p1,
  output logic       lamp_p2
`ifdef WARN_LOG_EN
  ,
  output logic [7:0] p1_evt_cnt
`endif
);

  typedef enum logic [2:0] {StIdle, StP1On, StP1Off, StP2On, StP2Off, StP2Mute} state_e;

  state_e      state_q, state_d;
  logic [15:0] presc_q, presc_d;
  logic [7:0]  phase_q, phase_d;
  logic [7:0]  rep_q, rep_d;
  logic        mute_q, mute_d;
  logic        lamp_p1_q, lamp_p2_q;
  logic        tick, phase_end, in_p1;
  logic [7:0]  phase_len;

  assign tick  = (presc_q == 16'(TICK_DIV - 1));
  assign in_p1 = (state_q == StP1On) || (state_q == StP1Off);

  always_comb begin
    phase_len = 8'd1;
    case (state_q)
      StP1On:  phase_len = 8'(P1_ON);
      StP1Off: phase_len = 8'(P1_OFF);
      StP2On:  phase_len = 8'(P2_ON);
      StP2Off: phase_len = 8'(P2_OFF);
      default: phase_len = 8'd1;
    endcase
  end

  assign phase_end = tick && (phase_q == phase_len - 8'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      presc_q   <= '0;
      phase_q   <= '0;
      rep_q     <= '0;
      mute_q    <= 1'b0;
      lamp_p1_q <= 1'b0;
      lamp_p2_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      phase_q   <= phase_d;
      rep_q     <= rep_d;
      mute_q    <= mute_d;
      lamp_p1_q <= warn_pri1;
      lamp_p2_q <= warn_pri2;
    end
  end

  always_comb begin
    state_d = state_q;
    rep_d   = rep_q;
    // Mute only survives while P2 stays asserted; ack/auto-mute below re-set it.
    mute_d  = warn_pri2 ? mute_q : 1'b0;
    if (warn_pri1 && !in_p1) begin
      state_d = StP1On;
    end else begin
      case (state_q)
        StP1On, StP1Off: begin
          if (!warn_pri1) begin
            if (warn_pri2) begin
              state_d = mute_q ? StP2Mute : StP2On;
              if (!mute_q) rep_d = '0;
            end else begin
              state_d = StIdle;
            end
          end else if (phase_end) begin
            state_d = (state_q == StP1On) ? StP1Off : StP1On;
          end
        end
        StIdle: begin
          if (warn_pri2) begin
            state_d = mute_q ? StP2Mute : StP2On;
            if (!mute_q) rep_d = '0;
          end
        end
        StP2On, StP2Off: begin
          if (ack) begin
            state_d = StP2Mute;
            mute_d  = 1'b1;
          end else if (!warn_pri2) begin
            state_d = StIdle;
            rep_d   = '0;
          end else if (phase_end) begin
            if (state_q == StP2On) begin
              state_d = StP2Off;
            end else if (rep_q + 8'd1 == 8'(P2_REPEAT)) begin
              state_d = StP2Mute;
              mute_d  = 1'b1;
            end else begin
              state_d = StP2On;
              rep_d   = rep_q + 8'd1;
            end
          end
        end
        StP2Mute: begin
          if (!warn_pri2) begin
            state_d = StIdle;
            rep_d   = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Every state change restarts the phase timing from zero.
  always_comb begin
    presc_d = tick ? '0 : presc_q + 16'd1;
    phase_d = tick ? phase_q + 8'd1 : phase_q;
    if (state_d != state_q) begin
      presc_d = '0;
      phase_d = '0;
    end
  end

  always_comb begin
    chime_out = (state_q == StP1On) || (state_q == StP2On);
    lamp_p1   = lamp_p1_q;
    lamp_p2   = lamp_p2_q;
  end

`ifdef WARN_LOG_EN
  logic [7:0] evt_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_cnt_q <= '0;
    end else if (warn_pri1 && !lamp_p1_q && (evt_cnt_q != 8'hff)) begin
      evt_cnt_q <= evt_cnt_q + 8'd1;
    end
  end

  assign p1_evt_cnt = evt_cnt_q;
`endif

endmodule

// File: tb/tb_warning_chime_ctrl.sv
// Directed bench for warning_chime_ctrl at default parameters.
// Define WARN_LOG_EN to also exercise the rising-edge event counter.
module tb_warning_chime_ctrl;

  logic clk = 1'b0;
  logic rst, warn_pri1, warn_pri2, ack;
  logic chime_out, lamp_p1, lamp_p2;
`ifdef WARN_LOG_EN
  logic [7:0] p1_evt_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  warning_chime_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .warn_pri1 (warn_pri1),
    .warn_pri2 (warn_pri2),
    .ack       (ack),
    .chime_out (chime_out),
    .lamp_p1   (lamp_p1),
    .lamp_p2   (lamp_p2)
`ifdef WARN_LOG_EN
    ,
    .p1_evt_cnt(p1_evt_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Advance one clock and sample just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full un-acked P2 sequence from IDLE: 3 x (4 high, 12 low), then silent.
  task automatic run_p2_fresh(input string tag);
    for (int k = 0; k < 60; k++) begin
      step();
      check(tag, {31'd0, chime_out}, (k < 48 && (k % 16) < 4) ? 32'd1 : 32'd0);
    end
    check({tag, "_lamp"}, {31'd0, lamp_p2}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; warn_pri1 = 1'b1; warn_pri2 = 1'b0; ack = 1'b0;

    // Reset overrides an asserted P1 warning.
    for (int k = 0; k < 2; k++) begin
      step();
      check("rst_chime", {31'd0, chime_out}, 32'd0);
      check("rst_lamps", {30'd0, lamp_p1, lamp_p2}, 32'd0);
    end
    rst = 1'b0;

    // P1 cadence: 8 high, 8 low; first edge after release enters P1_ON.
    for (int k = 0; k < 40; k++) begin
      step();
      check("p1_cadence", {31'd0, chime_out}, ((k % 16) < 8) ? 32'd1 : 32'd0);
      if (k == 0) check("p1_lamp", {31'd0, lamp_p1}, 32'd1);
    end
    warn_pri1 = 1'b0;
    step();
    check("p1_drop_chime", {31'd0, chime_out}, 32'd0);
    check("p1_drop_lamp", {31'd0, lamp_p1}, 32'd0);

    // P2 auto-mutes after three cadences.
    warn_pri2 = 1'b1;
    run_p2_fresh("p2_seq");
    warn_pri2 = 1'b0;
    step();
    check("p2_drop_lamp", {31'd0, lamp_p2}, 32'd0);
    check("p2_drop_chime", {31'd0, chime_out}, 32'd0);

    // Ack on the 2nd cycle of the first ON phase silences P2.
    warn_pri2 = 1'b1;
    step();
    check("ack_on0", {31'd0, chime_out}, 32'd1);
    step();
    check("ack_on1", {31'd0, chime_out}, 32'd1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("ack_mute", {31'd0, chime_out}, 32'd0);
    for (int k = 0; k < 30; k++) begin
      step();
      check("ack_stays_mute", {31'd0, chime_out}, 32'd0);
    end
    warn_pri2 = 1'b0;
    step();
    warn_pri2 = 1'b1;
    run_p2_fresh("p2_rearm");

    // P1 preempts a muted P2 and falls back to P2_MUTE.
    warn_pri1 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      check("preempt_p1", {31'd0, chime_out}, ((k % 16) < 8) ? 32'd1 : 32'd0);
    end
    warn_pri1 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check("back_to_mute", {31'd0, chime_out}, 32'd0);
    end
    check("back_lamps", {30'd0, lamp_p1, lamp_p2}, 32'd1);

    // Reset mid-cadence aborts at once.
    warn_pri2 = 1'b0;
    step();
    warn_pri1 = 1'b1;
    step();
    step();
    check("mid_on", {31'd0, chime_out}, 32'd1);
    rst = 1'b1;
    step();
    check("mid_rst_chime", {31'd0, chime_out}, 32'd0);
    check("mid_rst_lamp", {31'd0, lamp_p1}, 32'd0);
    warn_pri1 = 1'b0;
    step();
    rst = 1'b0;
    step();
    check("post_rst_idle", {31'd0, chime_out}, 32'd0);

`ifdef WARN_LOG_EN
    check("evt_reset", {24'd0, p1_evt_cnt}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      warn_pri1 = 1'b1; step();
      warn_pri1 = 1'b0; step(); step();
    end
    check("evt_three", {24'd0, p1_evt_cnt}, 32'd3);
    rst = 1'b1; step(); rst = 1'b0;
    for (int k = 0; k < 300; k++) begin
      warn_pri1 = 1'b1; step();
      warn_pri1 = 1'b0; step();
    end
    check("evt_saturate", {24'd0, p1_evt_cnt}, 32'd255);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
